// File: rtl/hazard_unit_pkg.sv
// lc3b_types: shared LC-3b datapath types.
//   lc3b_reg           - 3-bit architectural register index (R0..R7)
//   lc3b_hazard_state  - hazard controller FSM state encoding
//   LC3B_NOP           - instruction word loaded by bubble/flush controls
//   lc3b_load_use()    - load-use hazard detect, shared with anything else
//                        that needs the same R0-qualified match
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    IMEM_WAIT = 2'd2
  } lc3b_hazard_state;

  // BR with n/z/p all clear never branches, so the all-zero word is a NOP.
  localparam logic [15:0] LC3B_NOP = 16'h0000;

  // R0 is excluded to stay consistent with the forwarding path, which never
  // forwards to R0 either.
  function automatic logic lc3b_load_use(
    input logic    memread,
    input lc3b_reg dest,
    input lc3b_reg src1,
    input logic    src1_used,
    input lc3b_reg src2,
    input logic    src2_used
  );
    return memread && (dest != 3'd0) &&
           ((src1_used && (dest == src1)) || (src2_used && (dest == src2)));
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk, reset_n - clock, async active-low reset (clears count)
//   clr          - synchronous clear, wins over en
//   en           - increment this cycle (ignored once saturated)
//   q            - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the five-stage LC-3b pipeline.
// Handles the hazards forwarding cannot: load-use, imem/dmem wait states and
// taken-branch flushes, plus a data-memory wait watchdog.
//
// Optional build macro: HAZARD_PERF_EN adds stall_cycles / lu_events
// performance counters. Control behaviour is identical either way.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   src1_ifid/src2_ifid           sources of the instruction in ID
//   src1_used/src2_used           ID instruction really reads that source
//   dest_idex, idex_memread       destination / is-load of the EX instruction
//   exmem_memaccess, dmem_resp    MEM-stage data-memory access and response
//   imem_resp                     instruction-memory response
//   branch_taken_exmem            taken branch resolved in MEM
//   load_pc .. load_memwb         pipeline register load enables
//   bubble_idex                   load NOP into ID/EX instead of decode
//   flush_ifid, flush_idex        clear register to NOP on next load
//   timeout_err                   sticky dmem watchdog error
//   stall_cycles, lu_events       (HAZARD_PERF_EN only) saturating counters
//
// state     | meaning
// ----------+---------------------------------------------------
// RUN       | pipeline flowing (possibly a one-cycle load-use bubble)
// DMEM_WAIT | data memory outstanding, whole pipeline frozen
// IMEM_WAIT | instruction fetch outstanding, bubbles into ID/EX
module hazard_unit
  import lc3b_types::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  lc3b_reg     src1_ifid,
  input  lc3b_reg     src2_ifid,
  input  logic        src1_used,
  input  logic        src2_used,
  input  lc3b_reg     dest_idex,
  input  logic        idex_memread,
  input  logic        exmem_memaccess,
  input  logic        dmem_resp,
  input  logic        imem_resp,
  input  logic        branch_taken_exmem,
  output logic        load_pc,
  output logic        load_ifid,
  output logic        load_idex,
  output logic        load_exmem,
  output logic        load_memwb,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        flush_idex,
`ifdef HAZARD_PERF_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] lu_events,
`endif
  output logic        timeout_err
);

  lc3b_hazard_state state_q, state_n;

  logic             dmem_stall;
  logic             imem_stall;
  logic             lu;
  logic             lu_cycle;
  logic [CNT_W-1:0] wd_cnt;

  assign dmem_stall = exmem_memaccess && !dmem_resp;
  assign imem_stall = !imem_resp;
  assign lu         = lc3b_load_use(idex_memread, dest_idex, src1_ifid,
                                    src1_used, src2_ifid, src2_used);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_n;
    end
  end

  // A branch resolving on the same cycle as an imem miss redirects fetch,
  // so the stale fetch is dropped rather than waited on.
  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN: begin
        if (dmem_stall) begin
          state_n = DMEM_WAIT;
        end else if (!branch_taken_exmem && imem_stall) begin
          state_n = IMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        if (!dmem_stall) begin
          if (!branch_taken_exmem && imem_stall) begin
            state_n = IMEM_WAIT;
          end else begin
            state_n = RUN;
          end
        end
      end
      IMEM_WAIT: begin
        if (dmem_stall) begin
          state_n = DMEM_WAIT;
        end else if (imem_resp || branch_taken_exmem) begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // Outputs depend only on inputs and reset; the FSM state records which
  // wait is in progress for the watchdog and for observation.
  always_comb begin
    load_pc     = 1'b1;
    load_ifid   = 1'b1;
    load_idex   = 1'b1;
    load_exmem  = 1'b1;
    load_memwb  = 1'b1;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    lu_cycle    = 1'b0;
    if (!reset_n) begin
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (dmem_stall) begin
      // Freeze everything; a coincident branch stays in EX/MEM until resp.
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
    end else if (branch_taken_exmem) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (imem_stall) begin
      load_pc     = 1'b0;
      load_ifid   = 1'b0;
      bubble_idex = 1'b1;
    end else if (lu) begin
      // Single bubble: next cycle EX holds the NOP, so lu cannot repeat.
      load_pc     = 1'b0;
      load_ifid   = 1'b0;
      bubble_idex = 1'b1;
      lu_cycle    = 1'b1;
    end
  end

  // Watchdog holds at zero outside a dmem stall, so every stall episode
  // starts counting from zero. After the k-th consecutive stall cycle the
  // count is k; the error latches on the edge where it reaches MEM_TIMEOUT.
  sat_counter #(.W(CNT_W)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!dmem_stall),
    .en      (dmem_stall),
    .q       (wd_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (dmem_stall && (wd_cnt == CNT_W'(MEM_TIMEOUT - 1))) begin
      timeout_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  sat_counter #(.W(16)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .en      (!load_pc),
    .q       (stall_cycles)
  );

  sat_counter #(.W(16)) u_lu_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .en      (lu_cycle),
    .q       (lu_events)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import lc3b_types::*;

  logic    clk = 1'b0;
  logic    reset_n;
  lc3b_reg src1_ifid, src2_ifid, dest_idex;
  logic    src1_used, src2_used, idex_memread;
  logic    exmem_memaccess, dmem_resp, imem_resp, branch_taken_exmem;
  logic    load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic    bubble_idex, flush_ifid, flush_idex, timeout_err;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, lu_events;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [4:0] loads;
  assign loads = {load_pc, load_ifid, load_idex, load_exmem, load_memwb};

  hazard_unit #(.MEM_TIMEOUT(5), .CNT_W(8)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .src1_ifid          (src1_ifid),
    .src2_ifid          (src2_ifid),
    .src1_used          (src1_used),
    .src2_used          (src2_used),
    .dest_idex          (dest_idex),
    .idex_memread       (idex_memread),
    .exmem_memaccess    (exmem_memaccess),
    .dmem_resp          (dmem_resp),
    .imem_resp          (imem_resp),
    .branch_taken_exmem (branch_taken_exmem),
    .load_pc            (load_pc),
    .load_ifid          (load_ifid),
    .load_idex          (load_idex),
    .load_exmem         (load_exmem),
    .load_memwb         (load_memwb),
    .bubble_idex        (bubble_idex),
    .flush_ifid         (flush_ifid),
    .flush_idex         (flush_idex),
`ifdef HAZARD_PERF_EN
    .stall_cycles       (stall_cycles),
    .lu_events          (lu_events),
`endif
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    src1_ifid = 3'd0; src2_ifid = 3'd0; dest_idex = 3'd0;
    src1_used = 1'b0; src2_used = 1'b0; idex_memread = 1'b0;
    exmem_memaccess = 1'b0; dmem_resp = 1'b0; imem_resp = 1'b1;
    branch_taken_exmem = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b00000 || flush_ifid !== 1'b1 || flush_idex !== 1'b1 ||
        bubble_idex !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: loads=%b flush=%b%b bubble=%b err=%b, want 00000 11 0 0",
               loads, flush_ifid, flush_idex, bubble_idex, timeout_err);
    end
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111 || flush_ifid !== 1'b0 || dut.state_q !== RUN) begin
      tests_failed++;
      $display("FAIL reset_release: loads=%b flush_ifid=%b state=%0d, want 11111 0 RUN",
               loads, flush_ifid, dut.state_q);
    end
`ifdef HAZARD_PERF_EN
    tests_run++;
    if (stall_cycles !== 16'd0 || lu_events !== 16'd0) begin
      tests_failed++;
      $display("FAIL perf_reset: stall=%0d lu=%0d, want 0 0", stall_cycles, lu_events);
    end
`endif
    tick();
  endtask

  task automatic test_load_use();
    // LDR R3 in EX, ADD R?, R3 in ID
    idle();
    idex_memread = 1'b1; dest_idex = 3'd3; src1_ifid = 3'd3; src1_used = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b00111 || bubble_idex !== 1'b1 || flush_ifid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_stall: loads=%b bubble=%b flush=%b, want 00111 1 0",
               loads, bubble_idex, flush_ifid);
    end
    tick();
    // bubble now in EX: no load there anymore
    idex_memread = 1'b0; dest_idex = 3'd0;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111 || bubble_idex !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_resume: loads=%b bubble=%b, want 11111 0", loads, bubble_idex);
    end
`ifdef HAZARD_PERF_EN
    tests_run++;
    if (stall_cycles !== 16'd1 || lu_events !== 16'd1) begin
      tests_failed++;
      $display("FAIL perf_load_use: stall=%0d lu=%0d, want 1 1", stall_cycles, lu_events);
    end
`endif
    tick();
  endtask

  task automatic test_no_stall();
    idle();
    idex_memread = 1'b1; dest_idex = 3'd0; src1_ifid = 3'd0; src1_used = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111 || bubble_idex !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_r0: loads=%b bubble=%b, want 11111 0", loads, bubble_idex);
    end
    tick();
    idle();
    idex_memread = 1'b1; dest_idex = 3'd5; src1_ifid = 3'd2; src1_used = 1'b1;
    src2_ifid = 3'd5; src2_used = 1'b0;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111 || bubble_idex !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_src2_unused: loads=%b bubble=%b, want 11111 0", loads, bubble_idex);
    end
    tick();
    src2_used = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b00111 || bubble_idex !== 1'b1) begin
      tests_failed++;
      $display("FAIL lu_src2_used: loads=%b bubble=%b, want 00111 1", loads, bubble_idex);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_dmem_wait();
    idle();
    exmem_memaccess = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (loads !== 5'b00000 || (i > 0 && dut.state_q !== DMEM_WAIT)) begin
        tests_failed++;
        $display("FAIL dmem_wait_%0d: loads=%b state=%0d, want 00000 DMEM_WAIT",
                 i, loads, dut.state_q);
      end
      tick();
    end
    dmem_resp = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111) begin
      tests_failed++;
      $display("FAIL dmem_resp_cycle: loads=%b, want 11111", loads);
    end
    tick();
    idle();
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== RUN || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL dmem_exit: state=%0d err=%b, want RUN 0", dut.state_q, timeout_err);
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    branch_taken_exmem = 1'b1; imem_resp = 1'b0;
    idex_memread = 1'b1; dest_idex = 3'd4; src1_ifid = 3'd4; src1_used = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111 || flush_ifid !== 1'b1 || flush_idex !== 1'b1 ||
        bubble_idex !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_priority: loads=%b flush=%b%b bubble=%b, want 11111 11 0",
               loads, flush_ifid, flush_idex, bubble_idex);
    end
    tick();
    // branch frozen behind a dmem stall
    exmem_memaccess = 1'b1; dmem_resp = 1'b0; imem_resp = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b00000 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_frozen: loads=%b flush=%b%b, want 00000 00",
               loads, flush_ifid, flush_idex);
    end
    tick();
    dmem_resp = 1'b1;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b11111 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
      tests_failed++;
      $display("FAIL branch_after_resp: loads=%b flush=%b%b, want 11111 11",
               loads, flush_ifid, flush_idex);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_imem_wait();
    idle();
    imem_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (loads !== 5'b00111 || bubble_idex !== 1'b1) begin
      tests_failed++;
      $display("FAIL imem_stall: loads=%b bubble=%b, want 00111 1", loads, bubble_idex);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== IMEM_WAIT) begin
      tests_failed++;
      $display("FAIL imem_state: state=%0d, want IMEM_WAIT", dut.state_q);
    end
    exmem_memaccess = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== DMEM_WAIT || loads !== 5'b00000) begin
      tests_failed++;
      $display("FAIL imem_to_dmem: state=%0d loads=%b, want DMEM_WAIT 00000",
               dut.state_q, loads);
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    idle();
    exmem_memaccess = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      tests_run++;
      if (timeout_err !== (i >= 6)) begin
        tests_failed++;
        $display("FAIL timeout_cycle_%0d: err=%b, want %b", i, timeout_err, (i >= 6));
      end
      tick();
    end
    dmem_resp = 1'b1;
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b1 || loads !== 5'b11111) begin
      tests_failed++;
      $display("FAIL timeout_resp: err=%b loads=%b, want 1 11111", timeout_err, loads);
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky: err=%b, want 1", timeout_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle();
    exmem_memaccess = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (loads !== 5'b00000 || flush_ifid !== 1'b1 || flush_idex !== 1'b1 ||
        timeout_err !== 1'b0 || dut.state_q !== RUN) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: loads=%b flush=%b%b err=%b state=%0d, want 00000 11 0 RUN",
               loads, flush_ifid, flush_idex, timeout_err, dut.state_q);
    end
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== RUN || loads !== 5'b11111 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_run: state=%0d loads=%b err=%b, want RUN 11111 0",
               dut.state_q, loads, timeout_err);
    end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_dmem_wait();
    test_branch();
    test_imem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
